// File: rtl/controller_pkg.sv
// Shared types and defaults for the controller-source selector.
package controller_pkg;

  // Selection mode applied at each SNES latch rise.
  typedef enum logic [1:0] {
    MODE_MANUAL   = 2'b00,
    MODE_PRIORITY = 2'b01,
    MODE_LAST     = 2'b10,
    MODE_MERGE    = 2'b11
  } mode_t;

  localparam int BTN_W_DEFAULT = 8;

endpackage

// File: rtl/controller_mux_ch_holder.sv
// One channel of the controller mux: last received frame, idle counter and
// active flag. A channel goes inactive (and its frame clears) after
// TIMEOUT_CYC clocks without a fresh frame. TIMEOUT_CYC must be >= 2.
module ch_holder #(
  parameter int BTN_W       = 8,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             valid,
  input  logic [BTN_W-1:0] data,
  output logic [BTN_W-1:0] hold,
  output logic             active
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_r;
  logic [BTN_W-1:0] hold_r;
  logic             active_r;

  // Capture fresh frames; age active channels and drop them at expiry.
  // A fresh frame on the expiry cycle wins because it is tested first.
  // After expiry the counter stays at its last value until the next frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_r    <= '0;
      hold_r   <= '0;
      active_r <= 1'b0;
    end else if (valid) begin
      cnt_r    <= '0;
      hold_r   <= data;
      active_r <= 1'b1;
    end else if (active_r) begin
      if (cnt_r == CNT_LAST) begin
        hold_r   <= '0;
        active_r <= 1'b0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign hold   = hold_r;
  assign active = active_r;

endmodule

// File: rtl/controller_mux.sv
// Registered N-channel controller-source selector feeding snes_encoder.
// Outputs change only on a rising edge of the SNES latch so the frame is
// stable for the whole shift-out.
// Optional feature: define CONTROLLER_MUX_TURBO_EN to add turbo_mask and
// TURBO_DIV (auto-fire on masked buttons, toggling every TURBO_DIV rises).
module controller_mux
  import controller_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int BTN_W       = BTN_W_DEFAULT,
  parameter int SEL_W       = $clog2(NUM_CH),
  parameter int TIMEOUT_CYC = 1_000_000
`ifdef CONTROLLER_MUX_TURBO_EN
  ,
  parameter int TURBO_DIV   = 4
`endif
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_CH*BTN_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]       ch_valid,
  input  logic [1:0]              mode,
  input  logic [SEL_W-1:0]        man_sel,
  input  logic                    latch,
`ifdef CONTROLLER_MUX_TURBO_EN
  input  logic [BTN_W-1:0]        turbo_mask,
`endif
  output logic [BTN_W-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_active
);

  logic [NUM_CH*BTN_W-1:0] hold_flat_s;
  logic [NUM_CH-1:0]       active_s;
  logic [SEL_W-1:0]        last_ch_r;
  logic [SEL_W-1:0]        last_nxt_s;
  logic                    latch_q_r;
  logic                    rise_s;
  mode_t                   mode_s;
  logic [BTN_W-1:0]        sel_data_s;
  logic [SEL_W-1:0]        sel_ch_s;
  logic                    sel_active_s;
  logic [BTN_W-1:0]        turbo_keep_s;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ch_holder #(
      .BTN_W       (BTN_W),
      .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_ch_holder (
      .clock  (clock),
      .reset  (reset),
      .valid  (ch_valid[g]),
      .data   (ch_data[g*BTN_W +: BTN_W]),
      .hold   (hold_flat_s[g*BTN_W +: BTN_W]),
      .active (active_s[g])
    );
  end

  assign mode_s = mode_t'(mode);
  assign rise_s = latch & ~latch_q_r;

  // Most recent strobing channel; descending scan lets the lowest index win.
  always_comb begin
    last_nxt_s = last_ch_r;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_valid[i]) begin
        last_nxt_s = SEL_W'(i);
      end else begin
        last_nxt_s = last_nxt_s;
      end
    end
  end

  // Remember the latest source and the previous latch level.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_ch_r <= '0;
      latch_q_r <= 1'b0;
    end else begin
      last_ch_r <= last_nxt_s;
      latch_q_r <= latch;
    end
  end

  // Selection from the current hold/active state; descending scans make the
  // lowest active index the reported channel where several qualify.
  always_comb begin
    sel_data_s   = '0;
    sel_ch_s     = '0;
    sel_active_s = 1'b0;
    case (mode_s)
      MODE_MANUAL: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (man_sel == SEL_W'(i)) begin
            sel_data_s   = hold_flat_s[i*BTN_W +: BTN_W];
            sel_ch_s     = man_sel;
            sel_active_s = active_s[i];
          end else begin
            sel_ch_s = sel_ch_s;
          end
        end
      end
      MODE_PRIORITY: begin
        for (int i = NUM_CH - 1; i >= 0; i--) begin
          if (active_s[i]) begin
            sel_data_s   = hold_flat_s[i*BTN_W +: BTN_W];
            sel_ch_s     = SEL_W'(i);
            sel_active_s = 1'b1;
          end else begin
            sel_ch_s = sel_ch_s;
          end
        end
      end
      MODE_LAST: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (last_ch_r == SEL_W'(i)) begin
            sel_data_s   = hold_flat_s[i*BTN_W +: BTN_W];
            sel_ch_s     = last_ch_r;
            sel_active_s = active_s[i];
          end else begin
            sel_ch_s = sel_ch_s;
          end
        end
      end
      MODE_MERGE: begin
        for (int i = NUM_CH - 1; i >= 0; i--) begin
          if (active_s[i]) begin
            sel_data_s   = sel_data_s | hold_flat_s[i*BTN_W +: BTN_W];
            sel_ch_s     = SEL_W'(i);
            sel_active_s = 1'b1;
          end else begin
            sel_ch_s = sel_ch_s;
          end
        end
      end
      default: begin
        sel_data_s   = '0;
        sel_ch_s     = '0;
        sel_active_s = 1'b0;
      end
    endcase
  end

`ifdef CONTROLLER_MUX_TURBO_EN
  localparam int RC_W = (TURBO_DIV > 2) ? $clog2(TURBO_DIV) : 1;

  logic [RC_W-1:0] rise_cnt_r;
  logic            phase_r;

  // Count latch rises and flip the turbo phase every TURBO_DIV of them; the
  // frame registered on a rise uses the phase from before that rise.
  always_ff @(posedge clock) begin
    if (reset) begin
      rise_cnt_r <= '0;
      phase_r    <= 1'b0;
    end else if (rise_s) begin
      if (rise_cnt_r == RC_W'(TURBO_DIV - 1)) begin
        rise_cnt_r <= '0;
        phase_r    <= ~phase_r;
      end else begin
        rise_cnt_r <= rise_cnt_r + RC_W'(1);
      end
    end else begin
      rise_cnt_r <= rise_cnt_r;
    end
  end

  assign turbo_keep_s = ~(turbo_mask & {BTN_W{~phase_r}});
`else
  assign turbo_keep_s = '1;
`endif

  // Present the selection to the encoder only on a latch rise.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_data   <= '0;
      out_ch     <= '0;
      out_active <= 1'b0;
    end else if (rise_s) begin
      out_data   <= sel_data_s & turbo_keep_s;
      out_ch     <= sel_ch_s;
      out_active <= sel_active_s;
    end else begin
      out_active <= out_active;
    end
  end

endmodule
